// File: rtl/cache_byte_valid_tracker.sv
`default_nettype none
// ============================================================================
// Module   : cache_byte_valid_tracker
// Purpose  : Per-byte readability bits for every word, way and index of the
//            data cache. Refill/store paths set bits, line invalidation
//            clears them, and lookups report whether the requested bytes of
//            a word are readable. A clear sweep runs after every reset, and
//            lookup hit/miss statistics are kept.
// Revision : 1.0  initial release
// ============================================================================
module cache_byte_valid_tracker #(
  parameter int ADDR_WIDTH = 6,
  parameter int WAYS       = 4,
  parameter int WORD_BYTES = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int WAY_W     = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  input  logic                  lk_valid,
  input  logic [ADDR_WIDTH-1:0] lk_addr,
  input  logic [WAY_W-1:0]      lk_way,
  input  logic [WORD_BYTES-1:0] lk_byteEnable,
  output logic                  lk_respValid,
  output logic                  lk_hit,
  output logic [WORD_BYTES-1:0] lk_validBits,
  input  logic                  set_enable,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic [WAY_W-1:0]      set_way,
  input  logic [WORD_BYTES-1:0] set_byteEnable,
  input  logic                  inv_enable,
  input  logic [ADDR_WIDTH-1:0] inv_addr,
  input  logic [WAY_W-1:0]      inv_way,
  input  logic                  inv_allWays,
  output logic [CNT_WIDTH-1:0]  stat_lookups,
  output logic [CNT_WIDTH-1:0]  stat_misses
);

  localparam int                  c_DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = '1;
  localparam logic [CNT_WIDTH-1:0]  c_CNT_MAX  = '1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [ADDR_WIDTH-1:0]   r_sweepIdx;
  logic [WORD_BYTES-1:0]   r_valid [WAYS][c_DEPTH];

  logic                    r_respValid;
  logic                    r_hit;
  logic [WORD_BYTES-1:0]   r_validBits;
  logic [CNT_WIDTH-1:0]    r_lookups;
  logic [CNT_WIDTH-1:0]    r_misses;

  logic                    w_idle;
  logic                    w_accept;
  logic [WORD_BYTES-1:0]   w_lkCur;
  logic [WORD_BYTES-1:0]   w_lkSet;
  logic                    w_lkInv;
  logic [WORD_BYTES-1:0]   w_lkNext;
  logic                    w_lkHit;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && lk_valid;

  // State register: reset always restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state: leave CLEAR once the last index has been zeroed.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      CLEAR:   if (r_sweepIdx == c_LAST_IDX) w_stateNext = IDLE;
      IDLE:    w_stateNext = IDLE;
      default: w_stateNext = CLEAR;
    endcase
  end

  // Sweep index advances one entry per cycle while clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sweepIdx <= '0;
    end else if (r_state == CLEAR) begin
      r_sweepIdx <= r_sweepIdx + 1'b1;
    end
  end

  // Valid-bit array: sweep clears, otherwise set ORs in and invalidate wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int a = 0; a < c_DEPTH; a++) begin
          if (r_state == CLEAR) begin
            if (r_sweepIdx == ADDR_WIDTH'(a)) r_valid[w][a] <= '0;
          end else if (inv_enable && inv_addr == ADDR_WIDTH'(a) &&
                       (inv_allWays || inv_way == WAY_W'(w))) begin
            r_valid[w][a] <= '0;
          end else if (set_enable && set_addr == ADDR_WIDTH'(a) &&
                       set_way == WAY_W'(w)) begin
            r_valid[w][a] <= r_valid[w][a] | set_byteEnable;
          end
        end
      end
    end
  end

  // Write-first view of the looked-up entry, including same-cycle set/inv.
  always_comb begin
    w_lkCur  = r_valid[lk_way][lk_addr];
    w_lkSet  = (set_enable && set_addr == lk_addr && set_way == lk_way) ?
               set_byteEnable : '0;
    w_lkInv  = inv_enable && inv_addr == lk_addr &&
               (inv_allWays || inv_way == lk_way);
    w_lkNext = w_lkInv ? '0 : (w_lkCur | w_lkSet);
    w_lkHit  = ((w_lkNext & lk_byteEnable) == lk_byteEnable);
  end

  // Lookup response: registered one cycle after acceptance, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_respValid <= 1'b0;
      r_hit       <= 1'b0;
      r_validBits <= '0;
    end else begin
      r_respValid <= w_accept;
      if (w_accept) begin
        r_hit       <= w_lkHit;
        r_validBits <= w_lkNext;
      end
    end
  end

  // Saturating lookup and miss counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lookups <= '0;
      r_misses  <= '0;
    end else if (w_accept) begin
      if (r_lookups != c_CNT_MAX) r_lookups <= r_lookups + 1'b1;
      if (!w_lkHit && r_misses != c_CNT_MAX) r_misses <= r_misses + 1'b1;
    end
  end

  assign busy         = (r_state == CLEAR);
  assign lk_respValid = r_respValid;
  assign lk_hit       = r_hit;
  assign lk_validBits = r_validBits;
  assign stat_lookups = r_lookups;
  assign stat_misses  = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_cache_byte_valid_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_byte_valid_tracker
// Purpose  : Directed self-checking bench for cache_byte_valid_tracker with
//            small statistics counters so saturation is reachable.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_byte_valid_tracker;

  localparam int AW = 6;
  localparam int NW = 4;
  localparam int WB = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic          lk_valid;
  logic [AW-1:0] lk_addr;
  logic [1:0]    lk_way;
  logic [WB-1:0] lk_byteEnable;
  logic          lk_respValid;
  logic          lk_hit;
  logic [WB-1:0] lk_validBits;
  logic          set_enable;
  logic [AW-1:0] set_addr;
  logic [1:0]    set_way;
  logic [WB-1:0] set_byteEnable;
  logic          inv_enable;
  logic [AW-1:0] inv_addr;
  logic [1:0]    inv_way;
  logic          inv_allWays;
  logic [CW-1:0] stat_lookups;
  logic [CW-1:0] stat_misses;

  int total = 0;
  int bad   = 0;
  int expLookups = 0;
  int expMisses  = 0;
  int n;

  cache_byte_valid_tracker #(
    .ADDR_WIDTH(AW), .WAYS(NW), .WORD_BYTES(WB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .busy(busy),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_way(lk_way),
    .lk_byteEnable(lk_byteEnable), .lk_respValid(lk_respValid),
    .lk_hit(lk_hit), .lk_validBits(lk_validBits),
    .set_enable(set_enable), .set_addr(set_addr), .set_way(set_way),
    .set_byteEnable(set_byteEnable),
    .inv_enable(inv_enable), .inv_addr(inv_addr), .inv_way(inv_way),
    .inv_allWays(inv_allWays),
    .stat_lookups(stat_lookups), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [AW-1:0] a, input logic [1:0] w,
                        input logic [WB-1:0] be, input logic [WB-1:0] expBits,
                        input logic expHit, input string tag);
    lk_valid = 1'b1; lk_addr = a; lk_way = w; lk_byteEnable = be;
    step();
    lk_valid = 1'b0;
    if (expLookups < 15) expLookups++;
    if (!expHit && expMisses < 15) expMisses++;
    chk({tag, "_resp"}, 32'(lk_respValid), 32'd1);
    chk({tag, "_bits"}, 32'(lk_validBits), 32'(expBits));
    chk({tag, "_hit"}, 32'(lk_hit), 32'(expHit));
    chk({tag, "_nlk"}, 32'(stat_lookups), 32'(expLookups));
    chk({tag, "_nms"}, 32'(stat_misses), 32'(expMisses));
  endtask

  task automatic doSet(input logic [AW-1:0] a, input logic [1:0] w, input logic [WB-1:0] be);
    set_enable = 1'b1; set_addr = a; set_way = w; set_byteEnable = be;
    step();
    set_enable = 1'b0;
  endtask

  // Counts edges until busy drops; optionally pokes requests that must be ignored.
  task automatic waitSweep(input logic poke, output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      lk_valid = poke; lk_addr = 6'd2; lk_way = 2'd0; lk_byteEnable = 4'hF;
      set_enable = poke; set_addr = 6'd2; set_way = 2'd0; set_byteEnable = 4'hF;
      step();
      cycles++;
      if (poke) chk("sweep_noresp", 32'(lk_respValid), 32'd0);
    end
    lk_valid = 1'b0;
    set_enable = 1'b0;
    chk("sweep_done", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    lk_valid = 1'b0; lk_addr = '0; lk_way = '0; lk_byteEnable = '0;
    set_enable = 1'b0; set_addr = '0; set_way = '0; set_byteEnable = '0;
    inv_enable = 1'b0; inv_addr = '0; inv_way = '0; inv_allWays = 1'b0;

    // Reset state
    step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_resp", 32'(lk_respValid), 32'd0);
    chk("rst_hit", 32'(lk_hit), 32'd0);
    chk("rst_bits", 32'(lk_validBits), 32'd0);
    chk("rst_nlk", 32'(stat_lookups), 32'd0);
    chk("rst_nms", 32'(stat_misses), 32'd0);
    waitSweep(1'b0, n);
    chk("sweep_len", 32'(n), 32'd64);

    lookup(6'd0, 2'd0, 4'hF, 4'h0, 1'b0, "first");

    // Accumulating sets on one entry
    doSet(6'd5, 2'd2, 4'h3);
    doSet(6'd5, 2'd2, 4'h4);
    lookup(6'd5, 2'd2, 4'h7, 4'h7, 1'b1, "acc_hit");
    step();
    chk("hold_resp", 32'(lk_respValid), 32'd0);
    chk("hold_hit", 32'(lk_hit), 32'd1);
    chk("hold_bits", 32'(lk_validBits), 32'h7);
    lookup(6'd5, 2'd2, 4'hF, 4'h7, 1'b0, "acc_miss");
    lookup(6'd5, 2'd1, 4'hF, 4'h0, 1'b0, "other_way");

    // Same-cycle set + invalidate + lookup: invalidate wins
    set_enable = 1'b1; set_addr = 6'd9; set_way = 2'd0; set_byteEnable = 4'hF;
    inv_enable = 1'b1; inv_addr = 6'd9; inv_way = 2'd0;
    lookup(6'd9, 2'd0, 4'hF, 4'h0, 1'b0, "inv_wins");
    set_enable = 1'b0; inv_enable = 1'b0;

    // Same-cycle set + lookup: write-first
    set_enable = 1'b1; set_addr = 6'd10; set_way = 2'd3; set_byteEnable = 4'h5;
    lookup(6'd10, 2'd3, 4'h5, 4'h5, 1'b1, "wr_first");
    set_enable = 1'b0;

    // All-ways invalidate of one index
    for (int w = 0; w < NW; w++) doSet(6'd3, 2'(w), 4'hF);
    doSet(6'd4, 2'd1, 4'hA);
    inv_enable = 1'b1; inv_addr = 6'd3; inv_way = 2'd0; inv_allWays = 1'b1;
    step();
    inv_enable = 1'b0; inv_allWays = 1'b0;
    for (int w = 0; w < NW; w++) lookup(6'd3, 2'(w), 4'hF, 4'h0, 1'b0, "inv_all");
    lookup(6'd4, 2'd1, 4'hA, 4'hA, 1'b1, "idx4_kept");
    lookup(6'd3, 2'd0, 4'h0, 4'h0, 1'b1, "be_zero");

    // Reset during sweep restarts it; requests during sweep are ignored
    rst = 1'b1;
    step();
    rst = 1'b0;
    expLookups = 0;
    expMisses = 0;
    for (int i = 0; i < 30; i++) begin
      lk_valid = i[0]; lk_addr = 6'd2; lk_way = 2'd0; lk_byteEnable = 4'hF;
      step();
      chk("pre_noresp", 32'(lk_respValid), 32'd0);
    end
    lk_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    waitSweep(1'b1, n);
    chk("resweep_len", 32'(n), 32'd64);
    chk("resweep_nlk", 32'(stat_lookups), 32'd0);
    chk("resweep_nms", 32'(stat_misses), 32'd0);
    lookup(6'd2, 2'd0, 4'hF, 4'h0, 1'b0, "ign_set");
    lookup(6'd4, 2'd1, 4'hF, 4'h0, 1'b0, "swept");

    // Saturation with back-to-back misses
    for (int i = 0; i < 20; i++) lookup(6'd7, 2'd3, 4'hF, 4'h0, 1'b0, "sat");
    step();
    chk("sat_nlk", 32'(stat_lookups), 32'd15);
    chk("sat_nms", 32'(stat_misses), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_byte_valid_tracker.md
# cache_byte_valid_tracker

Per-byte readability tracker for the data cache: one valid bit per byte of every word, per way, per index. Refill and store paths mark bytes readable, line invalidation clears them, and lookups report whether all requested bytes of a word are readable. Generalises the fixed 4-way, 4-byte tracker with parameterised ways, word width and depth, plus post-reset clear sweep, invalidate, write-first lookup and hit/miss statistics. Sits beside the tag RAM in the cache read/write controller.

## Interface
- ADDR_WIDTH, 6, word index width; depth = 2**ADDR_WIDTH entries per way
- WAYS, 4, number of ways (power of two, >=2)
- WORD_BYTES, 4, bytes per word = valid bits per entry
- CNT_WIDTH, 16, statistics counter width
- WAY_W, $clog2(WAYS), derived (localparam)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- busy  out  1  clear sweep in progress; all requests ignored while high
- lk_valid  in  1  lookup request
- lk_addr  in  ADDR_WIDTH  lookup index
- lk_way  in  WAY_W  lookup way
- lk_byteEnable  in  WORD_BYTES  bytes needing to be readable
- lk_respValid  out  1  response valid (one cycle after accepted lookup)
- lk_hit  out  1  all enabled bytes readable
- lk_validBits  out  WORD_BYTES  full valid vector of looked-up entry
- set_enable  in  1  mark bytes readable
- set_addr  in  ADDR_WIDTH; set_way  in  WAY_W; set_byteEnable  in  WORD_BYTES
- inv_enable  in  1  clear bytes
- inv_addr  in  ADDR_WIDTH; inv_way  in  WAY_W
- inv_allWays  in  1  invalidate index in every way (inv_way ignored)
- stat_lookups  out  CNT_WIDTH  accepted lookups, saturating
- stat_misses  out  CNT_WIDTH  accepted lookups with lk_hit=0, saturating

## Operation
- Storage: flop array [ways][2**ADDR_WIDTH][WORD_BYTES]; no RAM macro, so set and invalidate may target different entries in the same cycle.
- States: CLEAR, IDLE.
  - rst=1 at an edge: state<=CLEAR, sweep counter<=0, lk_respValid<=0, lk_hit<=0, lk_validBits<=0, both stat counters<=0. busy is 1 from the cycle after the reset edge.
  - CLEAR: each cycle zero index=counter in all ways; counter+1. After writing index 2**ADDR_WIDTH-1 go to IDLE. Sweep lasts exactly 2**ADDR_WIDTH cycles. busy = (state==CLEAR).
  - rst asserted mid-sweep restarts sweep from index 0.
  - CLEAR ignores lk_valid, set_enable, inv_enable entirely (no state change, no response, no stats).
- IDLE update per entry E: next(E) = (cur(E) | S(E)) & ~I(E), where S = set_byteEnable if set targets E else 0, I = all-ones if inv targets E (inv_allWays matches any way at inv_addr) else 0. Invalidate wins over set on the same entry in the same cycle.
- Lookup (IDLE, lk_valid=1): at the edge, lk_validBits <= next(E) of looked-up entry (write-first: same-cycle set/inv visible); lk_hit <= ((next(E) & lk_byteEnable) == lk_byteEnable); lk_respValid <= 1. lk_byteEnable=0 is a hit.
- No lookup accepted: lk_respValid <= 0; lk_hit, lk_validBits hold previous values.
- Stats: accepted lookup increments stat_lookups; plus stat_misses if miss. Both saturate at 2**CNT_WIDTH-1, no wrap.

## Timing
- Lookup latency 1 cycle; throughput one lookup per cycle; no backpressure other than busy.
- Set/invalidate take effect at the edge they are sampled; visible to a lookup in the same cycle.
- First request accepted in the cycle busy is observed low (2**ADDR_WIDTH cycles after the reset edge).
- Outputs after reset edge: busy=1, lk_respValid=0, lk_hit=0, lk_validBits=0, stats=0.

## Test plan
- Reset, ADDR_WIDTH=6 -> busy high exactly 64 cycles; then lookup any entry, byteEnable=4'hF -> respValid=1 next cycle, hit=0, validBits=0; stat_lookups=1, stat_misses=1.
- Set idx 5 way 2 be=4'h3, then set be=4'h4; lookup be=4'h7 -> validBits=4'h7, hit=1; lookup be=4'hF -> hit=0; lookup way 1 idx 5 -> validBits=0.
- Same cycle: set idx 9 way 0 be=4'hF, inv idx 9 way 0, lookup idx 9 way 0 -> validBits=0, hit=0 (invalidate wins, write-first).
- Fill idx 3 all ways be=4'hF; inv idx 3 inv_allWays=1 -> every way at idx 3 reads 0; idx 4 entries unchanged.
- Assert rst at sweep cycle 30 -> busy stays high 64 more cycles; lk_valid pulses during sweep produce no respValid and no stat change.
- CNT_WIDTH=4: 20 back-to-back missing lookups -> stat_lookups=stat_misses=15, held.
